// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - forwarding select codes for the EX operand muxes
//   - scoreboard stage-tag structs (EX tag carries source-usage fields)
package hazard_pkg;

    localparam int unsigned TAG_RW = 5;  // register index width inside tags
    localparam int unsigned SEL_W  = 2;  // forwarding select width

    localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b01;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

    // Occupant of MEM or WB: just enough to know what it will write.
    typedef struct packed {
        logic              valid;
        logic [TAG_RW-1:0] rd;
        logic              rdEn;
        logic              load;
        logic              mem_op;
    } stage_tag_t;

    // Occupant of EX: also remembers which sources it reads.
    typedef struct packed {
        stage_tag_t        base;
        logic [TAG_RW-1:0] rs1;
        logic [TAG_RW-1:0] rs2;
        logic              rs1_read;
        logic              rs2_read;
    } ex_tag_t;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// fwd_select: combinational forwarding select for one EX operand.
// Ports:
//   ex_valid  in   EX occupant is a real instruction
//   rs        in   source index of this operand
//   rs_read   in   operand is actually read
//   mem_tag   in   EX/MEM occupant tag
//   wb_tag    in   MEM/WB occupant tag
//   sel       out  FWD_RF / FWD_MEM / FWD_WB
module fwd_select
    import hazard_pkg::*;
(
    input  logic              ex_valid,
    input  logic [TAG_RW-1:0] rs,
    input  logic              rs_read,
    input  stage_tag_t        mem_tag,
    input  stage_tag_t        wb_tag,
    output logic [SEL_W-1:0]  sel
);

    always_comb begin
        sel = FWD_RF;
        // x0 is never forwarded; a load in MEM has no data yet, so it
        // falls through to the WB check.
        if (ex_valid && rs_read && (rs != '0)) begin
            if (mem_tag.valid && mem_tag.rdEn && !mem_tag.load && (mem_tag.rd == rs))
                sel = FWD_MEM;
            else if (wb_tag.valid && wb_tag.rdEn && (wb_tag.rd == rs))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / freeze / forwarding controller for the
// 5-stage pipeline. Tracks EX, MEM and WB occupants in a private scoreboard.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_*                        decode-stage instruction fields
//   ex_redirect                 taken branch/jump resolved in EX
//   dm_ready                    data memory finishes MEM access this cycle
//   pc_stall, ifid_stall        hold PC / IF-ID
//   ifid_flush, idex_flush      bubble into IF-ID / ID-EX
//   pipe_freeze                 hold ID-EX, EX-MEM, MEM-WB
//   fwd_a_sel, fwd_b_sel        EX operand sources
//   wb_rdEn_q                   WB occupant writes the register file
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_read,
    input  logic              id_rs2_read,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rdEn,
    input  logic              id_DMread,
    input  logic              id_DMwrite,
    input  logic              ex_redirect,
    input  logic              dm_ready,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              pipe_freeze,
    output logic [FWD_W-1:0]  fwd_a_sel,
    output logic [FWD_W-1:0]  fwd_b_sel,
    output logic              wb_rdEn_q
);

    ex_tag_t    ex_q;
    stage_tag_t mem_q;
    stage_tag_t wb_q;
    ex_tag_t    id_tag;

    logic redirect;
    logic mem_wait;
    logic load_use;

    always_comb begin
        // Redirect is masked by reset so every control reads 0 during reset.
        redirect = ex_redirect & rst_n;
        mem_wait = mem_q.valid & mem_q.mem_op & ~dm_ready;
        load_use = id_valid & ex_q.base.valid & ex_q.base.load & ex_q.base.rdEn
                 & (ex_q.base.rd != '0)
                 & ((id_rs1_read & (id_rs1 == ex_q.base.rd)) |
                    (id_rs2_read & (id_rs2 == ex_q.base.rd)));

        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (mem_wait) begin
            pipe_freeze = 1'b1;
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
        end else if (redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    always_comb begin
        id_tag               = '0;
        id_tag.base.valid    = id_valid;
        id_tag.base.rd       = id_rd;
        id_tag.base.rdEn     = id_rdEn;
        id_tag.base.load     = id_DMread;
        id_tag.base.mem_op   = id_DMread | id_DMwrite;
        id_tag.rs1           = id_rs1;
        id_tag.rs2           = id_rs2;
        id_tag.rs1_read      = id_rs1_read;
        id_tag.rs2_read      = id_rs2_read;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_wait) begin
            wb_q  <= mem_q;
            mem_q <= ex_q.base;
            if (redirect || load_use || !id_valid)
                ex_q <= '0;
            else
                ex_q <= id_tag;
        end
    end

    assign wb_rdEn_q = wb_q.valid & wb_q.rdEn;

    fwd_select u_fwd_a (
        .ex_valid (ex_q.base.valid),
        .rs       (ex_q.rs1),
        .rs_read  (ex_q.rs1_read),
        .mem_tag  (mem_q),
        .wb_tag   (wb_q),
        .sel      (fwd_a_sel)
    );

    fwd_select u_fwd_b (
        .ex_valid (ex_q.base.valid),
        .rs       (ex_q.rs2),
        .rs_read  (ex_q.rs2_read),
        .mem_tag  (mem_q),
        .wb_tag   (wb_q),
        .sel      (fwd_b_sel)
    );

endmodule
